usb_packet_tx: RTL
==================

Name: usb_packet_tx

Overview:
- Parametrised USB packet transmitter: successor to the fixed-format transmitter top.
- Builds complete handshake (ACK/NAK/STALL) and DATA0/DATA1 packets:
  - SYNC, PID, payload from FIFO, CRC16, EOP.
  - Bit stuffing and NRZI encoding onto d_plus/d_minus.
- Payload length is per-packet and the bit rate is programmable.
- Sits between the receiver/controller (requests) and the USB line drivers.

Parameters:
- MAX_PAYLOAD, 64, maximum data bytes per DATA packet.
- CLKS_PER_BIT, 8, clk cycles per USB bit time (>=2).
- LOW_SPEED, 0, 1 swaps J/K polarity (J: d_plus=0, d_minus=1).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, synchronous, active-high
- tx_start  in  1  request pulse; sampled only in IDLE
- tx_pid_sel  in  2  0=ACK, 1=NAK, 2=STALL, 3=DATA
- data_len  in  $clog2(MAX_PAYLOAD+1)  payload bytes for DATA
- toggle_clr  in  1  forces data toggle to 0
- fifo_data  in  8  first-word-fall-through FIFO head byte
- fifo_r_enable  out  1  one-cycle pop pulse when fifo_data is latched
- is_txing  out  1  line enable; high while packet is on the line
- tx_done  out  1  one-cycle pulse after packet completes
- data_toggle  out  1  current DATA0(0)/DATA1(1) selection
- d_plus  out  1  USB D+
- d_minus  out  1  USB D-

Behaviour:
- Reset (one clk edge with rst=1, also mid-packet):
  - state IDLE; line at J (full speed: d_plus=1, d_minus=0).
  - is_txing=0, tx_done=0, fifo_r_enable=0, data_toggle=0.
  - stuff counter=0, CRC=0xFFFF.
  - A packet interrupted by reset is abandoned; no EOP is sent.
- Start:
  - tx_start=1 in IDLE latches tx_pid_sel and data_len (clamped to MAX_PAYLOAD).
  - is_txing=1 and first SYNC bit driven from the next cycle.
  - tx_start while busy is ignored.
- Bit timing: every line bit (including stuffed bits) is held exactly CLKS_PER_BIT cycles.
- Serialisation: LSB first.
- States and transitions:
  - IDLE -> SYNC: 0x80.
  - SYNC -> PID: ACK 0xD2, NAK 0x5A, STALL 0x1E, DATA0 0xC3, DATA1 0x4B.
  - PID -> EOP for handshakes; PID -> DATA if data_len>0; otherwise PID -> CRC.
  - DATA -> CRC after data_len bytes.
  - CRC -> EOP_SE0 (2 bits, d_plus=d_minus=0) -> EOP_J (1 bit J) -> DONE -> IDLE.
- FIFO handshake:
  - fifo_r_enable pulses once per payload byte, in the cycle fifo_data is loaded into the shift register.
  - The load occurs during the last bit-time of the previous byte, so bytes are sent with no gap.
  - The FIFO is never popped for handshakes or zero-length DATA.
- CRC16:
  - Polynomial x^16+x^15+x^2+1, init 0xFFFF, updated per payload bit (stuffed bits excluded).
  - Transmitted complemented, LSB first.
  - Zero-length payload sends 16 zero bits (0x0000).
- Bit stuffing:
  - Counts consecutive raw 1s from SYNC through the CRC's last bit.
  - After the 6th consecutive 1, a 0 is inserted and the counter is cleared; any 0 also clears it.
  - A stuff pending after the final CRC bit is still sent before EOP.
  - The counter is cleared on entry to EOP.
- NRZI:
  - Raw 0 toggles the line level; raw 1 holds it.
  - The initial level is J at the start of SYNC.
- Completion:
  - is_txing falls after the last cycle of EOP_J.
  - tx_done pulses for one cycle (DONE) with is_txing=0.
  - For DATA packets data_toggle flips at DONE.
- Toggle:
  - toggle_clr=1 forces data_toggle=0 next cycle.
  - If toggle_clr coincides with DONE, toggle_clr wins.

Test Plan:
- ACK, CLKS_PER_BIT=4 -> is_txing high 76 cycles.
  - Line bits: K J K J K J K K, then J J K J J K K K, then SE0 SE0 J.
  - tx_done 1 cycle; no fifo_r_enable.
- DATA, data_len=0, toggle=0 -> PID 0xC3 sent, 16 zero CRC bits, 35 bit times total, data_toggle becomes 1, no FIFO pops.
- DATA, data_len=2, FIFO 0xFF,0xFF:
  - Exactly 2 fifo_r_enable pulses, no inter-byte gap.
  - 3 stuffed 0s inside the payload region.
  - Decoded CRC matches the golden model.
- DATA, data_len=MAX_PAYLOAD+5 -> exactly MAX_PAYLOAD pops.
- tx_start re-asserted mid-packet -> ignored.
- toggle_clr on the DONE cycle -> data_toggle=0.
- rst asserted during DATA payload -> next cycle line J, is_txing=0, data_toggle=0; following ACK request transmits a correct packet.

Source files
------------

// File: rtl/usb_packet_tx.sv
// USB packet transmitter: SYNC, PID, optional FIFO payload with CRC16, then EOP.
// Serialises LSB first with bit stuffing and NRZI onto d_plus/d_minus.
module usb_packet_tx #(
    parameter int unsigned MAX_PAYLOAD  = 64,
    parameter int unsigned CLKS_PER_BIT = 8,
    parameter bit          LOW_SPEED    = 1'b0
) (
    input  logic                               clk,
    input  logic                               rst,
    input  logic                               tx_start,
    input  logic [1:0]                         tx_pid_sel,
    input  logic [$clog2(MAX_PAYLOAD+1)-1:0]   data_len,
    input  logic                               toggle_clr,
    input  logic [7:0]                         fifo_data,
    output logic                               fifo_r_enable,
    output logic                               is_txing,
    output logic                               tx_done,
    output logic                               data_toggle,
    output logic                               d_plus,
    output logic                               d_minus
);

    localparam int unsigned     LenW     = $clog2(MAX_PAYLOAD + 1);
    localparam int unsigned     CntW     = $clog2(CLKS_PER_BIT);
    localparam logic [LenW-1:0] MaxLen   = LenW'(MAX_PAYLOAD);
    localparam logic [CntW-1:0] BitLast  = CntW'(CLKS_PER_BIT - 1);
    localparam logic [1:0]      SelData  = 2'd3;
    localparam logic [7:0]      SyncByte = 8'h80;

    typedef enum logic [2:0] {
        StIdle,
        StSync,
        StPid,
        StData,
        StCrc,
        StEopSe0,
        StEopJ,
        StDone
    } state_e;

    state_e          state_q, state_d;
    logic [CntW-1:0] bit_cnt_q, bit_cnt_d;
    logic [3:0]      bit_idx_q, bit_idx_d;
    logic [15:0]     shift_q, shift_d;
    logic [15:0]     crc_q, crc_d;
    logic [2:0]      stuff_cnt_q, stuff_cnt_d;
    logic            stuffing_q, stuffing_d;
    logic            level_q, level_d;
    logic [1:0]      pid_sel_q, pid_sel_d;
    logic [7:0]      pid_q, pid_d;
    logic [LenW-1:0] pops_left_q, pops_left_d;
    logic [7:0]      byte_buf_q, byte_buf_d;
    logic            buf_valid_q, buf_valid_d;
    logic            toggle_q, toggle_d;

    logic            bit_end;
    logic            last_bit;
    logic            is_data;
    logic            emit_en;
    logic            emit_bit;
    logic            crc_en;
    logic            crc_bit;
    logic [7:0]      start_pid;
    logic [LenW-1:0] start_len;

    assign is_data     = (pid_sel_q == SelData);
    assign bit_end     = (bit_cnt_q == BitLast);
    assign last_bit    = (state_q == StCrc) ? (bit_idx_q == 4'd15) : (bit_idx_q == 4'd7);
    assign start_len   = (data_len > MaxLen) ? MaxLen : data_len;
    assign data_toggle = toggle_q;
    assign tx_done     = (state_q == StDone);
    assign is_txing    = (state_q != StIdle) && (state_q != StDone);

    // Next payload byte is fetched during the last raw bit of the byte on the line.
    assign fifo_r_enable = ((state_q == StPid) || (state_q == StData)) && is_data &&
                           (bit_idx_q == 4'd7) && !stuffing_q && (bit_cnt_q == '0) &&
                           (pops_left_q != '0);

    always_comb begin
        case (tx_pid_sel)
            2'd0:    start_pid = 8'hD2;
            2'd1:    start_pid = 8'h5A;
            2'd2:    start_pid = 8'h1E;
            default: start_pid = toggle_q ? 8'h4B : 8'hC3;
        endcase
    end

    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        bit_idx_d   = bit_idx_q;
        shift_d     = shift_q;
        crc_d       = crc_q;
        stuff_cnt_d = stuff_cnt_q;
        stuffing_d  = stuffing_q;
        level_d     = level_q;
        pid_sel_d   = pid_sel_q;
        pid_d       = pid_q;
        pops_left_d = pops_left_q;
        byte_buf_d  = byte_buf_q;
        buf_valid_d = buf_valid_q;
        toggle_d    = toggle_q;
        emit_en     = 1'b0;
        emit_bit    = 1'b0;
        crc_en      = 1'b0;
        crc_bit     = 1'b0;

        if (is_txing) begin
            bit_cnt_d = bit_end ? '0 : bit_cnt_q + 1'b1;
        end

        if (fifo_r_enable) begin
            byte_buf_d  = fifo_data;
            buf_valid_d = 1'b1;
            pops_left_d = pops_left_q - 1'b1;
        end

        unique case (state_q)
            StIdle: begin
                level_d = 1'b1;
                if (tx_start) begin
                    state_d     = StSync;
                    bit_cnt_d   = '0;
                    bit_idx_d   = '0;
                    shift_d     = {8'h00, SyncByte};
                    crc_d       = 16'hFFFF;
                    stuffing_d  = 1'b0;
                    pid_sel_d   = tx_pid_sel;
                    pid_d       = start_pid;
                    pops_left_d = (tx_pid_sel == SelData) ? start_len : '0;
                    buf_valid_d = 1'b0;
                    emit_en     = 1'b1;
                    emit_bit    = SyncByte[0];
                end
            end
            StSync, StPid, StData, StCrc: begin
                if (bit_end) begin
                    if (stuff_cnt_q == 3'd6) begin
                        // Stuffed zero: line position does not advance.
                        stuffing_d = 1'b1;
                        emit_en    = 1'b1;
                        emit_bit   = 1'b0;
                    end else begin
                        stuffing_d = 1'b0;
                        if (!last_bit) begin
                            shift_d   = {1'b0, shift_q[15:1]};
                            bit_idx_d = bit_idx_q + 4'd1;
                            emit_en   = 1'b1;
                            emit_bit  = shift_q[1];
                            crc_en    = (state_q == StData);
                            crc_bit   = shift_q[1];
                        end else begin
                            bit_idx_d = '0;
                            if (state_q == StSync) begin
                                state_d  = StPid;
                                shift_d  = {8'h00, pid_q};
                                emit_en  = 1'b1;
                                emit_bit = pid_q[0];
                            end else if (state_q == StCrc || !is_data) begin
                                state_d     = StEopSe0;
                                stuff_cnt_d = '0;
                                level_d     = 1'b1;
                            end else if (buf_valid_q) begin
                                state_d     = StData;
                                shift_d     = {8'h00, byte_buf_q};
                                buf_valid_d = 1'b0;
                                emit_en     = 1'b1;
                                emit_bit    = byte_buf_q[0];
                                crc_en      = 1'b1;
                                crc_bit     = byte_buf_q[0];
                            end else begin
                                state_d  = StCrc;
                                shift_d  = ~crc_q;
                                emit_en  = 1'b1;
                                emit_bit = ~crc_q[0];
                            end
                        end
                    end
                end
            end
            StEopSe0: begin
                if (bit_end) begin
                    if (bit_idx_q == 4'd1) begin
                        state_d   = StEopJ;
                        bit_idx_d = '0;
                    end else begin
                        bit_idx_d = bit_idx_q + 4'd1;
                    end
                end
            end
            StEopJ: begin
                if (bit_end) begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
                if (is_data) begin
                    toggle_d = ~toggle_q;
                end
            end
            default: state_d = StIdle;
        endcase

        if (toggle_clr) begin
            toggle_d = 1'b0;
        end

        // NRZI: a raw 0 toggles the line, a raw 1 holds it.
        if (emit_en) begin
            level_d     = emit_bit ? level_q : ~level_q;
            stuff_cnt_d = emit_bit ? stuff_cnt_q + 3'd1 : 3'd0;
        end

        if (crc_en) begin
            crc_d = {1'b0, crc_q[15:1]} ^ ((crc_q[0] ^ crc_bit) ? 16'hA001 : 16'h0000);
        end
    end

    always_comb begin
        unique case (state_q)
            StEopSe0: begin
                d_plus  = 1'b0;
                d_minus = 1'b0;
            end
            StSync, StPid, StData, StCrc: begin
                d_plus  = level_q ^ LOW_SPEED;
                d_minus = ~level_q ^ LOW_SPEED;
            end
            default: begin
                d_plus  = ~LOW_SPEED;
                d_minus = LOW_SPEED;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= StIdle;
            bit_cnt_q   <= '0;
            bit_idx_q   <= '0;
            shift_q     <= '0;
            crc_q       <= 16'hFFFF;
            stuff_cnt_q <= '0;
            stuffing_q  <= 1'b0;
            level_q     <= 1'b1;
            pid_sel_q   <= '0;
            pid_q       <= '0;
            pops_left_q <= '0;
            byte_buf_q  <= '0;
            buf_valid_q <= 1'b0;
            toggle_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            bit_idx_q   <= bit_idx_d;
            shift_q     <= shift_d;
            crc_q       <= crc_d;
            stuff_cnt_q <= stuff_cnt_d;
            stuffing_q  <= stuffing_d;
            level_q     <= level_d;
            pid_sel_q   <= pid_sel_d;
            pid_q       <= pid_d;
            pops_left_q <= pops_left_d;
            byte_buf_q  <= byte_buf_d;
            buf_valid_q <= buf_valid_d;
            toggle_q    <= toggle_d;
        end
    end

endmodule
